// File: rtl/full_adder.sv
// full_adder: registered WIDTH-bit ripple-carry adder with optional carry chaining across words.
// Latency: 1 cycle from an accepted operand set to sum/cout/out_valid.
// Backpressure: none; one operation is accepted on every edge where in_valid is high.

// One ripple stage: sum and carry-out for a single bit position.
module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic s,
  output logic co
);

  logic p;

  // Propagate term is shared by the sum and the carry-out.
  always_comb begin
    p  = a ^ b;
    s  = p ^ c;
    co = (a & b) | (c & p);
  end

endmodule

module full_adder #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             chain,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             out_valid
);

  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum_bits;
  logic             carry_in;

  logic [WIDTH-1:0] sum_d,       sum_q;
  logic             cout_d,      cout_q;
  logic             out_valid_d, out_valid_q;

  // Chained operations continue from the visible registered carry-out; no hidden carry exists.
  always_comb begin
    carry_in = chain ? cout_q : cin;
  end

  assign carry[0] = carry_in;

  // Ripple chain: bit i consumes carry[i] and produces carry[i+1].
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    full_adder_cell u_cell (
      .a  (a[i]),
      .b  (b[i]),
      .c  (carry[i]),
      .s  (sum_bits[i]),
      .co (carry[i+1])
    );
  end

  // Load the new result on an accepted operation, otherwise hold; out_valid pulses per accept.
  // The hold path never looks at a/b/cin, so undriven operands on idle cycles cannot leak out.
  always_comb begin
    sum_d       = sum_q;
    cout_d      = cout_q;
    out_valid_d = 1'b0;
    if (in_valid) begin
      sum_d       = sum_bits;
      cout_d      = carry[WIDTH];
      out_valid_d = 1'b1;
    end
  end

  // Result registers; reset clears the result and therefore the chain carry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q       <= '0;
      cout_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      sum_q       <= sum_d;
      cout_q      <= cout_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign sum       = sum_q;
  assign cout      = cout_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_full_adder.sv
// tb_full_adder: checks a 1-bit and an 8-bit full_adder against an arithmetic reference model.
// Expected results are queued when operands are driven and popped one cycle later.
// Inputs change on the falling edge; outputs are sampled 1 time unit after the rising edge.
module tb_full_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic       in_valid1, cin1, chain1, cout1, ov1;
  logic [0:0] a1, b1, sum1;
  logic       in_valid8, cin8, chain8, cout8, ov8;
  logic [7:0] a8, b8, sum8;

  full_adder #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .a(a1), .b(b1), .cin(cin1),
    .chain(chain1), .sum(sum1), .cout(cout1), .out_valid(ov1)
  );

  full_adder #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .a(a8), .b(b8), .cin(cin8),
    .chain(chain8), .sum(sum8), .cout(cout8), .out_valid(ov8)
  );

  typedef struct packed {logic [7:0] sum; logic cout;} exp8_t;
  typedef struct packed {logic sum; logic cout;} exp1_t;

  exp8_t q8[$];
  exp1_t q1[$];

  // Reference state: last accepted result of each adder.
  logic [7:0] m_sum8;
  logic       m_cout8;
  logic       m_sum1;
  logic       m_cout1;

  int n_checks = 0;
  int n_fail   = 0;

  // Drive one accepted 8-bit operation and queue its expected result.
  task automatic drive8(input logic [7:0] a, input logic [7:0] b, input logic c, input logic ch);
    logic [8:0] tot;
    logic       cc;
    @(negedge clk);
    in_valid8 = 1'b1; a8 = a; b8 = b; cin8 = c; chain8 = ch;
    cc  = ch ? m_cout8 : c;
    tot = {1'b0, a} + {1'b0, b} + {8'd0, cc};
    m_sum8  = tot[7:0];
    m_cout8 = tot[8];
    q8.push_back(exp8_t'{sum: tot[7:0], cout: tot[8]});
  endtask

  // Drive one accepted 1-bit operation and queue its expected result.
  task automatic drive1(input logic a, input logic b, input logic c, input logic ch);
    logic [1:0] tot;
    logic       cc;
    @(negedge clk);
    in_valid1 = 1'b1; a1 = a; b1 = b; cin1 = c; chain1 = ch;
    cc  = ch ? m_cout1 : c;
    tot = {1'b0, a} + {1'b0, b} + {1'b0, cc};
    m_sum1  = tot[0];
    m_cout1 = tot[1];
    q1.push_back(exp1_t'{sum: tot[0], cout: tot[1]});
  endtask

  task automatic idle8(input logic [7:0] a, input logic [7:0] b, input logic c);
    @(negedge clk);
    in_valid8 = 1'b0; a8 = a; b8 = b; cin8 = c; chain8 = 1'b0;
  endtask

  task automatic idle1(input logic a, input logic b, input logic c);
    @(negedge clk);
    in_valid1 = 1'b0; a1 = a; b1 = b; cin1 = c; chain1 = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      in_valid1 = 1'b1; a1 = 1'($urandom); b1 = 1'($urandom); cin1 = 1'($urandom); chain1 = 1'($urandom);
      in_valid8 = 1'b1; a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom); chain8 = 1'($urandom);
      @(posedge clk); #1;
      n_checks++;
      if ({cout8, sum8, ov8, cout1, sum1, ov1} !== 13'd0) begin
        n_fail++;
        $display("FAIL reset_hold cycle %0d: got sum8=%h cout8=%b ov8=%b sum1=%b cout1=%b ov1=%b, expected all 0",
                 i, sum8, cout8, ov8, sum1, cout1, ov1);
      end
    end
    idle8(8'h00, 8'h00, 1'b0);
    idle1(1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    m_sum8 = 8'h00; m_cout8 = 1'b0; m_sum1 = 1'b0; m_cout1 = 1'b0;
    // Load a nonzero result, then assert reset between edges.
    drive8(8'hFF, 8'h01, 1'b0, 1'b0);
    @(posedge clk); #1;
    begin
      exp8_t e = q8.pop_front();
      n_checks++;
      if ({cout8, sum8, ov8} !== {e.cout, e.sum, 1'b1}) begin
        n_fail++;
        $display("FAIL reset_preload: got cout=%b sum=%h ov=%b, expected cout=%b sum=%h ov=1", cout8, sum8, ov8, e.cout, e.sum);
      end
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({cout8, sum8, ov8} !== 10'd0) begin
      n_fail++;
      $display("FAIL reset_async: got cout=%b sum=%h ov=%b before next edge, expected all 0", cout8, sum8, ov8);
    end
    m_sum8 = 8'h00; m_cout8 = 1'b0;
    in_valid8 = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_exhaustive_w1;
    for (int i = 0; i < 8; i++) begin
      drive1(1'(i >> 2), 1'(i >> 1), 1'(i), 1'b0);
      @(posedge clk); #1;
      if (q1.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL w1_combo %0d: scoreboard empty", i);
      end else begin
        exp1_t e = q1.pop_front();
        n_checks++;
        if ({cout1, sum1, ov1} !== {e.cout, e.sum, 1'b1}) begin
          n_fail++;
          $display("FAIL w1_combo a=%0d b=%0d cin=%0d: got cout=%b sum=%b ov=%b, expected cout=%b sum=%b ov=1",
                   (i >> 2) & 1, (i >> 1) & 1, i & 1, cout1, sum1, ov1, e.cout, e.sum);
        end
      end
    end
    idle1(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_hold;
    drive1(1'b1, 1'b0, 1'b1, 1'b0);
    @(posedge clk); #1;
    begin
      exp1_t e = q1.pop_front();
      n_checks++;
      if ({cout1, sum1, ov1} !== {e.cout, e.sum, 1'b1}) begin
        n_fail++;
        $display("FAIL hold_load: got cout=%b sum=%b ov=%b, expected cout=%b sum=%b ov=1", cout1, sum1, ov1, e.cout, e.sum);
      end
    end
    for (int i = 0; i < 3; i++) begin
      idle1(1'b0, 1'b0, 1'b0);
      @(posedge clk); #1;
      n_checks++;
      if ({cout1, sum1, ov1} !== {m_cout1, m_sum1, 1'b0}) begin
        n_fail++;
        $display("FAIL hold_idle cycle %0d: got cout=%b sum=%b ov=%b, expected cout=%b sum=%b ov=0",
                 i, cout1, sum1, ov1, m_cout1, m_sum1);
      end
    end
  endtask

  task automatic test_boundary_w8;
    logic [7:0] ta [3];
    logic [7:0] tb [3];
    logic       tc [3];
    ta = '{8'hFF, 8'hFF, 8'h00};
    tb = '{8'h01, 8'hFF, 8'h00};
    tc = '{1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 3; i++) begin
      drive8(ta[i], tb[i], tc[i], 1'b0);
      @(posedge clk); #1;
      begin
        exp8_t e = q8.pop_front();
        n_checks++;
        if ({cout8, sum8, ov8} !== {e.cout, e.sum, 1'b1}) begin
          n_fail++;
          $display("FAIL w8_boundary %h+%h+%b: got cout=%b sum=%h ov=%b, expected cout=%b sum=%h ov=1",
                   ta[i], tb[i], tc[i], cout8, sum8, ov8, e.cout, e.sum);
        end
      end
    end
    idle8(8'h00, 8'h00, 1'b0);
  endtask

  task automatic test_chain_w8;
    // 0x01FF + 0x0001 as two words, then a chain across idle cycles.
    drive8(8'hFF, 8'h01, 1'b0, 1'b0);
    @(posedge clk); #1;
    n_checks++;
    if ({cout8, sum8} !== 9'h100) begin
      n_fail++;
      $display("FAIL chain_low: got cout=%b sum=%h, expected cout=1 sum=00", cout8, sum8);
    end
    void'(q8.pop_front());
    drive8(8'h01, 8'h00, 1'b0, 1'b1);
    @(posedge clk); #1;
    n_checks++;
    if ({cout8, sum8, ov8} !== {1'b0, 8'h02, 1'b1}) begin
      n_fail++;
      $display("FAIL chain_high: got cout=%b sum=%h ov=%b, expected cout=0 sum=02 ov=1", cout8, sum8, ov8);
    end
    void'(q8.pop_front());
    drive8(8'hFF, 8'hFF, 1'b0, 1'b0);
    idle8(8'h00, 8'h00, 1'b0);
    idle8(8'h00, 8'h00, 1'b0);
    drive8(8'h00, 8'h00, 1'b0, 1'b1);
    @(posedge clk); #1;
    q8.delete();
    n_checks++;
    if ({cout8, sum8, ov8} !== {1'b0, 8'h01, 1'b1}) begin
      n_fail++;
      $display("FAIL chain_gap: got cout=%b sum=%h ov=%b, expected cout=0 sum=01 ov=1", cout8, sum8, ov8);
    end
    idle8(8'h00, 8'h00, 1'b0);
  endtask

  task automatic test_reset_mid_chain;
    drive8(8'hF0, 8'h20, 1'b0, 1'b0);
    @(posedge clk); #1;
    void'(q8.pop_front());
    n_checks++;
    if (cout8 !== 1'b1) begin
      n_fail++;
      $display("FAIL rmc_setup: got cout=%b, expected 1", cout8);
    end
    @(negedge clk);
    in_valid8 = 1'b0;
    #2 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    m_sum8 = 8'h00; m_cout8 = 1'b0;
    drive8(8'h00, 8'h00, 1'b1, 1'b1);
    @(posedge clk); #1;
    n_checks++;
    if ({cout8, sum8, ov8} !== {1'b0, 8'h00, 1'b1}) begin
      n_fail++;
      $display("FAIL rmc_after: got cout=%b sum=%h ov=%b, expected cout=0 sum=00 ov=1", cout8, sum8, ov8);
    end
    void'(q8.pop_front());
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 40; i++) begin
      drive8(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
      @(posedge clk); #1;
      if (q8.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL b2b %0d: scoreboard empty", i);
      end else begin
        exp8_t e = q8.pop_front();
        n_checks++;
        if ({cout8, sum8, ov8} !== {e.cout, e.sum, 1'b1}) begin
          n_fail++;
          $display("FAIL b2b %0d a=%h b=%h cin=%b chain=%b: got cout=%b sum=%h ov=%b, expected cout=%b sum=%h ov=1",
                   i, a8, b8, cin8, chain8, cout8, sum8, ov8, e.cout, e.sum);
        end
      end
    end
    idle8(8'h00, 8'h00, 1'b0);
    @(posedge clk); #1;
    n_checks++;
    if (ov8 !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_drain: got ov=%b, expected 0", ov8);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    in_valid1 = 1'b0; a1 = 1'b0; b1 = 1'b0; cin1 = 1'b0; chain1 = 1'b0;
    in_valid8 = 1'b0; a8 = 8'h00; b8 = 8'h00; cin8 = 1'b0; chain8 = 1'b0;
    m_sum8 = 8'h00; m_cout8 = 1'b0; m_sum1 = 1'b0; m_cout1 = 1'b0;
    test_reset();
    test_exhaustive_w1();
    test_hold();
    test_boundary_w8();
    test_chain_w8();
    test_reset_mid_chain();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/full_adder.md
# full_adder

Registered full adder, single-bit by default and parameterizable to a WIDTH-bit ripple-carry adder built from per-bit full-adder cells. Computes {cout, sum} = a + b + carry-in and registers the result on the clock. A chain mode feeds the previous registered carry-out back in as carry-in, so wide operands can be added over several consecutive words. It is the basic arithmetic leaf used by datapath blocks and by adder-chain tests.

## Interface
- WIDTH, 1, operand and sum width in bits (≥1).
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands valid this cycle; the result is captured only when high.
- a  input  WIDTH  operand A (unsigned).
- b  input  WIDTH  operand B (unsigned).
- cin  input  1  external carry-in, used when chain=0.
- chain  input  1  when 1, the carry-in is the registered cout of the last accepted operation and cin is ignored.
- sum  output  WIDTH  registered sum bits.
- cout  output  1  registered carry-out (MSB of the WIDTH+1-bit total).
- out_valid  output  1  high for one cycle after each accepted operation.

## Operation
- Per-bit cell: s_i = a_i ^ b_i ^ c_i; c_{i+1} = (a_i & b_i) | (c_i & (a_i ^ b_i)). c_0 is the effective carry-in, and cout = c_WIDTH.
- The effective carry-in is chain ? cout (registered value) : cin.
- The result is exact unsigned arithmetic: {cout, sum} = a + b + carry_in, computed at WIDTH+1 bits with no truncation and no overflow flag.
- When in_valid=1 at a rising edge, sum and cout load the new result and out_valid becomes 1.
- When in_valid=0 at a rising edge, sum and cout hold their previous values and out_valid becomes 0.
- The chain carry source is always the currently visible cout register. No separate hidden carry state exists.
- X or Z on a, b or cin while in_valid=0 has no effect on the outputs.

## Timing
- Latency is 1 cycle: operands presented at edge N appear on sum/cout, with out_valid=1, after edge N.
- Throughput is one operation per cycle. Back-to-back valid cycles produce back-to-back out_valid.
- The combinational path from input to register is the full WIDTH-bit ripple. There is no combinational path from input to output.
- Reset (rst_n=0) takes effect immediately and asynchronously: sum=0, cout=0, out_valid=0. The chain carry is therefore 0 after reset.
- A reset asserted mid-sequence discards the in-flight result and the chained carry. The first valid operation after rst_n deasserts uses the normal carry selection, and chain=1 sees carry 0.
- rst_n deassertion is synchronized externally. The block samples inputs on the first rising edge with rst_n=1.
- Chain on consecutive cycles: the cout produced at edge N is the carry-in for the operation accepted at edge N+1. This is also true when in_valid was low in between, because cout holds.

## Test plan
- Reset: hold rst_n=0 with random inputs and toggling clk -> sum=0, cout=0, out_valid=0 throughout. Assert rst_n asynchronously between edges -> outputs clear before the next edge.
- WIDTH=1 exhaustive: apply all 8 combinations of (a,b,cin), each with in_valid=1 and chain=0 -> one cycle later {cout,sum} = a+b+cin. Spot checks: (0,0,0)->0/0, (0,0,1)->0/1, (1,1,0)->1/0, (1,1,1)->1/1, with out_valid=1 each cycle.
- Hold: load a=1,b=0,cin=1 (result cout=1,sum=0), then drive in_valid=0 with a=0,b=0,cin=0 for 3 cycles -> cout=1, sum=0 held, out_valid=0.
- WIDTH=8 boundary: 0xFF+0x01+0 -> sum=0x00, cout=1. 0xFF+0xFF+1 -> sum=0xFF, cout=1. 0x00+0x00+0 -> sum=0x00, cout=0.
- Chain, WIDTH=8: add 16-bit 0x01FF + 0x0001 as two words.
  - Low word 0xFF+0x01 with chain=0, cin=0 -> sum=0x00, cout=1.
  - Next cycle, high word 0x01+0x00 with chain=1 and cin=0 (ignored) -> sum=0x02, cout=0.
- Reset mid-chain: produce cout=1, pulse rst_n low, then apply a=0,b=0 with chain=1 -> sum=0, cout=0.
